sync_fifo_wconv: RTL and testbench

SYNC_FIFO_WCONV -- requirements
Module: sync_fifo_wconv

---
 rtl/fifo_pkg.sv | 48 ++++
 rtl/fifo_unit_ram.sv | 31 +++
 rtl/sync_fifo_wconv.sv | 141 ++++++++++++++
 tb/tb_sync_fifo_wconv.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - width-conversion helper constants and functions for the unit FIFO
package fifo_pkg;

    typedef enum logic [1:0] {
        MODE_EQUAL = 2'd0,
        MODE_UP    = 2'd1,
        MODE_DOWN  = 2'd2
    } conv_mode_e;

    function automatic conv_mode_e fifo_mode(input int wr_w, input int rd_w);
        if (wr_w == rd_w) return MODE_EQUAL;
        if (wr_w < rd_w) return MODE_UP;
        return MODE_DOWN;
    endfunction

    function automatic int fifo_ratio(input int wr_w, input int rd_w);
        return (wr_w > rd_w) ? (wr_w / rd_w) : (rd_w / wr_w);
    endfunction

    // Returns -1 for any ratio the unit datapath cannot handle.
    function automatic int fifo_ratio_log2(input int ratio);
        case (ratio)
            1:       return 0;
            2:       return 1;
            4:       return 2;
            8:       return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit fifo_ratio_legal(input int wr_w, input int rd_w);
        int hi;
        int lo;
        hi = (wr_w > rd_w) ? wr_w : rd_w;
        lo = (wr_w > rd_w) ? rd_w : wr_w;
        if (lo <= 0 || (hi % lo) != 0) return 1'b0;
        return fifo_ratio_log2(hi / lo) >= 0;
    endfunction

    function automatic int fifo_wr_units(input int wr_w, input int rd_w);
        return (wr_w > rd_w) ? (wr_w / rd_w) : 1;
    endfunction

    function automatic int fifo_rd_units(input int wr_w, input int rd_w);
        return (rd_w > wr_w) ? (rd_w / wr_w) : 1;
    endfunction

endpackage

// File: rtl/fifo_unit_ram.sv
// rtl/fifo_unit_ram.sv - narrow-unit storage with multi-unit write and async multi-unit read
module fifo_unit_ram #(
    parameter int UNIT_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int WR_UNITS = 1,
    parameter int RD_UNITS = 2
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [UNIT_W*WR_UNITS-1:0]   wdata,
    input  logic [ADDR_W-1:0]            raddr,
    output logic [UNIT_W*RD_UNITS-1:0]   rdata
);

    logic [UNIT_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < WR_UNITS; i++) begin
                mem[waddr + ADDR_W'(i)] <= wdata[i*UNIT_W +: UNIT_W];
            end
        end
    end

    // Lowest-addressed unit lands in the LSBs of the read word.
    for (genvar i = 0; i < RD_UNITS; i++) begin : g_rd
        assign rdata[i*UNIT_W +: UNIT_W] = mem[raddr + ADDR_W'(i)];
    end

endmodule

// File: rtl/sync_fifo_wconv.sv
// rtl/sync_fifo_wconv.sv - single-clock FIFO with power-of-two write/read width conversion
module sync_fifo_wconv
    import fifo_pkg::*;
#(
    parameter int WR_DATA_WIDTH    = 16,
    parameter int RD_DATA_WIDTH    = 32,
    parameter int UNIT_DEPTH_WIDTH = 11,
    parameter int ALMOST_FULL_NUM  = (2 ** UNIT_DEPTH_WIDTH) / fifo_wr_units(WR_DATA_WIDTH, RD_DATA_WIDTH) - 4,
    parameter int ALMOST_EMPTY_NUM = 4,
    parameter int FWFT             = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [WR_DATA_WIDTH-1:0]      wr_data,
    output logic                          wr_full,
    output logic                          almost_full,
    output logic [UNIT_DEPTH_WIDTH:0]     wr_water_level,
    output logic                          wr_overflow,
    input  logic                          rd_en,
    output logic [RD_DATA_WIDTH-1:0]      rd_data,
    output logic                          rd_empty,
    output logic                          almost_empty,
    output logic [UNIT_DEPTH_WIDTH:0]     rd_water_level,
    output logic                          rd_underflow
);

    localparam conv_mode_e MODE   = fifo_mode(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int RATIO          = fifo_ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
    localparam int RATIO_LOG2     = fifo_ratio_log2(RATIO);
    localparam int NARROW_W       = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int WR_UNITS       = (MODE == MODE_DOWN) ? RATIO : 1;
    localparam int RD_UNITS       = (MODE == MODE_UP) ? RATIO : 1;
    localparam int WR_LOG2        = (MODE == MODE_DOWN) ? RATIO_LOG2 : 0;
    localparam int RD_LOG2        = (MODE == MODE_UP) ? RATIO_LOG2 : 0;
    localparam int PW             = UNIT_DEPTH_WIDTH + 1;
    localparam int DEPTH          = 1 << UNIT_DEPTH_WIDTH;
    localparam int AF_NUM         = (ALMOST_FULL_NUM < 0) ? 0 : ALMOST_FULL_NUM;
    localparam int AE_NUM         = (ALMOST_EMPTY_NUM < 0) ? 0 : ALMOST_EMPTY_NUM;

    localparam logic [PW-1:0] WR_STEP    = PW'(WR_UNITS);
    localparam logic [PW-1:0] RD_STEP    = PW'(RD_UNITS);
    localparam logic [PW-1:0] FULL_LIMIT = PW'(DEPTH - WR_UNITS);
    localparam logic [PW-1:0] AF_LVL     = PW'(AF_NUM);
    localparam logic [PW-1:0] AE_LVL     = PW'(AE_NUM);

    if (!fifo_ratio_legal(WR_DATA_WIDTH, RD_DATA_WIDTH)) begin : g_bad_ratio
        $error("sync_fifo_wconv: width ratio must be 1, 2, 4 or 8");
    end
    if (UNIT_DEPTH_WIDTH < 4 || UNIT_DEPTH_WIDTH > 16) begin : g_bad_depth
        $error("sync_fifo_wconv: UNIT_DEPTH_WIDTH must be within 4..16");
    end

    logic [PW-1:0]             wr_ptr;
    logic [PW-1:0]             rd_ptr;
    logic [PW-1:0]             wr_ptr_nxt;
    logic [PW-1:0]             rd_ptr_nxt;
    logic [PW-1:0]             count_nxt;
    logic [PW-1:0]             wr_lvl_nxt;
    logic [PW-1:0]             rd_lvl_nxt;
    logic                      wr_accept;
    logic                      rd_accept;
    logic [RD_DATA_WIDTH-1:0]  ram_rdata;

    // Acceptance uses the registered flags, so a same-cycle pop never frees room for a write.
    always_comb begin
        wr_accept  = wr_en && !wr_full && !flush;
        rd_accept  = rd_en && !rd_empty && !flush;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (wr_accept) wr_ptr_nxt = wr_ptr + WR_STEP;
            if (rd_accept) rd_ptr_nxt = rd_ptr + RD_STEP;
        end
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
        wr_lvl_nxt = count_nxt >> WR_LOG2;
        rd_lvl_nxt = count_nxt >> RD_LOG2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            wr_full        <= 1'b0;
            almost_full    <= (AF_NUM == 0);
            wr_water_level <= '0;
            wr_overflow    <= 1'b0;
            rd_empty       <= 1'b1;
            almost_empty   <= 1'b1;
            rd_water_level <= '0;
            rd_underflow   <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            wr_full        <= count_nxt > FULL_LIMIT;
            almost_full    <= wr_lvl_nxt >= AF_LVL;
            wr_water_level <= wr_lvl_nxt;
            wr_overflow    <= !flush && wr_en && wr_full;
            rd_empty       <= count_nxt < RD_STEP;
            almost_empty   <= rd_lvl_nxt <= AE_LVL;
            rd_water_level <= rd_lvl_nxt;
            rd_underflow   <= !flush && rd_en && rd_empty;
        end
    end

    fifo_unit_ram #(
        .UNIT_W   (NARROW_W),
        .ADDR_W   (UNIT_DEPTH_WIDTH),
        .WR_UNITS (WR_UNITS),
        .RD_UNITS (RD_UNITS)
    ) u_ram (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr[UNIT_DEPTH_WIDTH-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[UNIT_DEPTH_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is shown straight from storage; zero while nothing complete is stored.
        assign rd_data = rd_empty ? '0 : ram_rdata;
    end else begin : g_std
        logic [RD_DATA_WIDTH-1:0] rd_data_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else if (rd_accept) begin
                rd_data_q <= ram_rdata;
            end
        end

        assign rd_data = rd_data_q;
    end

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// tb/tb_sync_fifo_wconv.sv - randomized self-checking bench against a unit-queue model
module tb_sync_fifo_wconv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    bit          we [3];
    bit          re [3];
    bit          fl [3];
    logic [31:0] wd [3];

    logic        a_full, a_af, a_ovf, a_empty, a_ae, a_unf;
    logic [4:0]  a_wwl, a_rwl;
    logic [31:0] a_rd;
    logic        b_full, b_af, b_ovf, b_empty, b_ae, b_unf;
    logic [4:0]  b_wwl, b_rwl;
    logic [15:0] b_rd;
    logic        c_full, c_af, c_ovf, c_empty, c_ae, c_unf;
    logic [4:0]  c_wwl, c_rwl;
    logic [31:0] c_rd;

    sync_fifo_wconv #(.WR_DATA_WIDTH(16), .RD_DATA_WIDTH(32), .UNIT_DEPTH_WIDTH(4), .FWFT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]), .wr_en(we[0]), .wr_data(wd[0][15:0]),
        .wr_full(a_full), .almost_full(a_af), .wr_water_level(a_wwl), .wr_overflow(a_ovf),
        .rd_en(re[0]), .rd_data(a_rd), .rd_empty(a_empty), .almost_empty(a_ae),
        .rd_water_level(a_rwl), .rd_underflow(a_unf));

    sync_fifo_wconv #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(16), .UNIT_DEPTH_WIDTH(4), .FWFT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]), .wr_en(we[1]), .wr_data(wd[1]),
        .wr_full(b_full), .almost_full(b_af), .wr_water_level(b_wwl), .wr_overflow(b_ovf),
        .rd_en(re[1]), .rd_data(b_rd), .rd_empty(b_empty), .almost_empty(b_ae),
        .rd_water_level(b_rwl), .rd_underflow(b_unf));

    sync_fifo_wconv #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(32), .UNIT_DEPTH_WIDTH(4), .FWFT(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(fl[2]), .wr_en(we[2]), .wr_data(wd[2][7:0]),
        .wr_full(c_full), .almost_full(c_af), .wr_water_level(c_wwl), .wr_overflow(c_ovf),
        .rd_en(re[2]), .rd_data(c_rd), .rd_empty(c_empty), .almost_empty(c_ae),
        .rd_water_level(c_rwl), .rd_underflow(c_unf));

    // Per instance: narrow unit width, units per write, units per read, FWFT mode.
    localparam int NW [3] = '{16, 16, 8};
    localparam int UW [3] = '{1, 2, 1};
    localparam int UR [3] = '{2, 1, 4};
    localparam int FW [3] = '{0, 1, 0};
    localparam int DEPTH_UNITS = 16;

    logic [15:0] mq [3][$];
    logic [31:0] m_data [3];
    bit          m_ovf [3];
    bit          m_unf [3];

    int n_total = 0;
    int n_pass  = 0;

    task automatic model_edge(input int d);
        int          sz;
        bit          full;
        bit          empty;
        logic [31:0] w;
        logic [31:0] mask;
        sz    = mq[d].size();
        full  = (DEPTH_UNITS - sz) < UW[d];
        empty = sz < UR[d];
        mask  = (NW[d] == 16) ? 32'hFFFF : 32'hFF;
        if (fl[d]) begin
            mq[d].delete();
            m_ovf[d] = 1'b0;
            m_unf[d] = 1'b0;
        end else begin
            m_ovf[d] = we[d] && full;
            m_unf[d] = re[d] && empty;
            if (re[d] && !empty) begin
                w = '0;
                for (int i = 0; i < UR[d]; i++) w |= 32'(mq[d].pop_front()) << (i * NW[d]);
                m_data[d] = w;
            end
            if (we[d] && !full) begin
                for (int i = 0; i < UW[d]; i++) mq[d].push_back(16'((wd[d] >> (i * NW[d])) & mask));
            end
        end
    endtask

    function automatic logic [15:0] exp_status(input int d);
        int sz;
        int wwl;
        int rwl;
        sz  = mq[d].size();
        wwl = sz / UW[d];
        rwl = sz / UR[d];
        return {(DEPTH_UNITS - sz) < UW[d], wwl >= (DEPTH_UNITS / UW[d] - 4), 5'(wwl), m_ovf[d],
                sz < UR[d], rwl <= 4, 5'(rwl), m_unf[d]};
    endfunction

    function automatic logic [31:0] exp_head(input int d);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < UR[d]; i++) w |= 32'(mq[d][i]) << (i * NW[d]);
        return w;
    endfunction

    function automatic logic [15:0] obs_status(input int d);
        case (d)
            0:       return {a_full, a_af, a_wwl, a_ovf, a_empty, a_ae, a_rwl, a_unf};
            1:       return {b_full, b_af, b_wwl, b_ovf, b_empty, b_ae, b_rwl, b_unf};
            default: return {c_full, c_af, c_wwl, c_ovf, c_empty, c_ae, c_rwl, c_unf};
        endcase
    endfunction

    function automatic logic [31:0] obs_data(input int d);
        case (d)
            0:       return a_rd;
            1:       return {16'h0, b_rd};
            default: return c_rd;
        endcase
    endfunction

    task automatic set_idle();
        for (int d = 0; d < 3; d++) begin
            we[d] = 1'b0;
            re[d] = 1'b0;
            fl[d] = 1'b0;
            wd[d] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                mq[d].delete();
                m_data[d] = '0;
                m_ovf[d]  = 1'b0;
                m_unf[d]  = 1'b0;
            end else begin
                model_edge(d);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            n_total++;
            if (obs_status(d) !== exp_status(d))
                $display("FAIL reset_status dut%0d got=%h exp=%h", d, obs_status(d), exp_status(d));
            else n_pass++;
            n_total++;
            if (obs_data(d) !== 32'h0)
                $display("FAIL reset_rd_data dut%0d got=%h exp=0", d, obs_data(d));
            else n_pass++;
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pair();
        we[0] = 1'b1; wd[0] = 32'h1111; tick();
        wd[0] = 32'h2222; tick();
        we[0] = 1'b0;
        n_total++;
        if (a_empty !== 1'b0) $display("FAIL pair_empty got=%b exp=0", a_empty);
        else n_pass++;
        n_total++;
        if (obs_status(0) !== exp_status(0))
            $display("FAIL pair_status got=%h exp=%h", obs_status(0), exp_status(0));
        else n_pass++;
        re[0] = 1'b1; tick();
        re[0] = 1'b0;
        n_total++;
        if (a_rd !== 32'h22221111) $display("FAIL pair_rd_data got=%h exp=22221111", a_rd);
        else n_pass++;
        tick();
        n_total++;
        if (a_rd !== 32'h22221111) $display("FAIL pair_rd_hold got=%h exp=22221111", a_rd);
        else n_pass++;
    endtask

    task automatic test_fwft();
        we[1] = 1'b1; wd[1] = 32'hAABBCCDD; tick();
        we[1] = 1'b0;
        n_total++;
        if ({b_empty, b_rd} !== {1'b0, 16'hCCDD})
            $display("FAIL fwft_head got=%b/%h exp=0/ccdd", b_empty, b_rd);
        else n_pass++;
        re[1] = 1'b1; tick();
        n_total++;
        if ({b_empty, b_rd} !== {1'b0, 16'hAABB})
            $display("FAIL fwft_pop1 got=%b/%h exp=0/aabb", b_empty, b_rd);
        else n_pass++;
        tick();
        re[1] = 1'b0;
        n_total++;
        if (b_empty !== 1'b1) $display("FAIL fwft_pop2_empty got=%b exp=1", b_empty);
        else n_pass++;
        n_total++;
        if (obs_status(1) !== exp_status(1))
            $display("FAIL fwft_status got=%h exp=%h", obs_status(1), exp_status(1));
        else n_pass++;
    endtask

    task automatic test_full_overflow();
        logic [15:0] wrote [16];
        we[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wrote[i] = 16'($urandom);
            wd[0] = {16'h0, wrote[i]};
            tick();
        end
        n_total++;
        if ({a_full, a_wwl} !== {1'b1, 5'd16})
            $display("FAIL full_level got=%b/%0d exp=1/16", a_full, a_wwl);
        else n_pass++;
        wd[0] = 32'hDEAD; tick();
        we[0] = 1'b0;
        n_total++;
        if (a_ovf !== 1'b1) $display("FAIL overflow_pulse got=%b exp=1", a_ovf);
        else n_pass++;
        n_total++;
        if (obs_status(0) !== exp_status(0))
            $display("FAIL overflow_status got=%h exp=%h", obs_status(0), exp_status(0));
        else n_pass++;
        tick();
        n_total++;
        if (a_ovf !== 1'b0) $display("FAIL overflow_clear got=%b exp=0", a_ovf);
        else n_pass++;
        re[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_total++;
            if (a_rd !== {wrote[2*k+1], wrote[2*k]})
                $display("FAIL full_drain_%0d got=%h exp=%h", k, a_rd, {wrote[2*k+1], wrote[2*k]});
            else n_pass++;
        end
        re[0] = 1'b0;
    endtask

    task automatic test_underflow();
        re[0] = 1'b1; tick();
        re[0] = 1'b0;
        n_total++;
        if ({a_unf, a_rd} !== {1'b1, m_data[0]})
            $display("FAIL underflow got=%b/%h exp=1/%h", a_unf, a_rd, m_data[0]);
        else n_pass++;
        tick();
        n_total++;
        if (a_unf !== 1'b0) $display("FAIL underflow_clear got=%b exp=0", a_unf);
        else n_pass++;
        we[0] = 1'b1; wd[0] = 32'h5A5A; tick();
        we[0] = 1'b0;
        tick();
        n_total++;
        if (a_empty !== 1'b1) $display("FAIL partial_word_empty got=%b exp=1", a_empty);
        else n_pass++;
        n_total++;
        if (obs_status(0) !== exp_status(0))
            $display("FAIL partial_word_status got=%h exp=%h", obs_status(0), exp_status(0));
        else n_pass++;
    endtask

    task automatic test_flush();
        we[0] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wd[0] = $urandom;
            tick();
        end
        fl[0] = 1'b1; re[0] = 1'b1; tick();
        fl[0] = 1'b0; re[0] = 1'b0; we[0] = 1'b0;
        n_total++;
        if ({a_empty, a_wwl, a_rwl} !== {1'b1, 5'd0, 5'd0})
            $display("FAIL flush_levels got=%b/%0d/%0d exp=1/0/0", a_empty, a_wwl, a_rwl);
        else n_pass++;
        n_total++;
        if ({obs_status(0), a_rd} !== {exp_status(0), m_data[0]})
            $display("FAIL flush_state got=%h/%h exp=%h/%h", obs_status(0), a_rd, exp_status(0), m_data[0]);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        we[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wd[0] = $urandom;
            tick();
        end
        we[0] = 1'b0;
        rst_n = 1'b0;
        tick();
        n_total++;
        if ({a_empty, a_wwl, a_rd} !== {1'b1, 5'd0, 32'h0})
            $display("FAIL midop_reset got=%b/%0d/%h exp=1/0/0", a_empty, a_wwl, a_rd);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        we[0] = 1'b1; wd[0] = 32'hBEEF; tick();
        wd[0] = 32'hCAFE; tick();
        we[0] = 1'b0; re[0] = 1'b1; tick();
        re[0] = 1'b0;
        n_total++;
        if (a_rd !== 32'hCAFEBEEF) $display("FAIL midop_first_word got=%h exp=cafebeef", a_rd);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit did_rd;
        we[2] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wd[2] = $urandom;
            tick();
        end
        for (int k = 0; k < 64; k++) begin
            wd[2]  = $urandom;
            re[2]  = (k % 4) == 3;
            did_rd = re[2];
            tick();
            n_total++;
            if (obs_status(2) !== exp_status(2))
                $display("FAIL wrap_status_%0d got=%h exp=%h", k, obs_status(2), exp_status(2));
            else n_pass++;
            if (did_rd) begin
                n_total++;
                if (c_rd !== m_data[2]) $display("FAIL wrap_data_%0d got=%h exp=%h", k, c_rd, m_data[2]);
                else n_pass++;
            end
        end
        set_idle();
    endtask

    task automatic test_random();
        int wp;
        int rp;
        for (int k = 0; k < 900; k++) begin
            wp = ((k / 150) % 2 == 0) ? 3 : 1;
            rp = ((k / 150) % 2 == 0) ? 1 : 3;
            for (int d = 0; d < 3; d++) begin
                we[d] = ($urandom % 4) < wp;
                re[d] = ($urandom % 4) < rp;
                fl[d] = ($urandom % 97) == 0;
                wd[d] = $urandom;
            end
            tick();
            for (int d = 0; d < 3; d++) begin
                n_total++;
                if (obs_status(d) !== exp_status(d))
                    $display("FAIL rand_status dut%0d cyc%0d got=%h exp=%h", d, k, obs_status(d), exp_status(d));
                else n_pass++;
                if (FW[d] == 0) begin
                    n_total++;
                    if (obs_data(d) !== m_data[d])
                        $display("FAIL rand_data dut%0d cyc%0d got=%h exp=%h", d, k, obs_data(d), m_data[d]);
                    else n_pass++;
                end else if (mq[d].size() >= UR[d]) begin
                    n_total++;
                    if (obs_data(d) !== exp_head(d))
                        $display("FAIL rand_head dut%0d cyc%0d got=%h exp=%h", d, k, obs_data(d), exp_head(d));
                    else n_pass++;
                end
            end
        end
        set_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_pair();
        test_fwft();
        test_full_overflow();
        test_underflow();
        test_flush();
        test_reset_midop();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
